// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the 1-cycle imem, and buffers up to two tagged instructions for decode.
// Optional FETCH_PERF_EN adds the pop and flush performance counters.
module fetch_unit #(
    parameter int          PC_W     = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    output logic [PC_W-1:0] address_imem,
    input  logic [31:0]     q_imem,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_out,
    output logic [31:0]     inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    logic [31:0] fpc_q, fpc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflightPc_q, inflightPc_d;
    logic [31:0] fifoInst_q [2];
    logic [31:0] fifoInst_d [2];
    logic [31:0] fifoPc_q [2];
    logic [31:0] fifoPc_d [2];
    logic [1:0]  occ_q, occ_d;

    logic        pop;
    logic        issue;
    logic [2:0]  pending;
    logic [1:0]  occAfterPop;

    assign inst_valid   = (occ_q != 2'd0);
    assign inst_out     = fifoInst_q[0];
    assign inst_pc      = fifoPc_q[0];
    assign address_imem = fpc_q[PC_W-1:0];

    assign pop     = inst_valid & inst_ready;
    // Counts slots that will be occupied once this cycle's pop and in-flight return settle.
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue   = !redirect_valid && (pending < 3'd2);
    assign occAfterPop = occ_q - {1'b0, pop};

    always_comb begin
        fpc_d        = fpc_q;
        inflight_d   = 1'b0;
        inflightPc_d = inflightPc_q;
        fifoInst_d   = fifoInst_q;
        fifoPc_d     = fifoPc_q;
        occ_d        = occAfterPop;

        if (pop) begin
            fifoInst_d[0] = fifoInst_q[1];
            fifoPc_d[0]   = fifoPc_q[1];
        end

        if (inflight_q) begin
            if (occAfterPop == 2'd0) begin
                fifoInst_d[0] = q_imem;
                fifoPc_d[0]   = inflightPc_q;
            end else begin
                fifoInst_d[1] = q_imem;
                fifoPc_d[1]   = inflightPc_q;
            end
            occ_d = occAfterPop + 2'd1;
        end

        if (issue) begin
            inflight_d   = 1'b1;
            inflightPc_d = fpc_q;
            fpc_d        = fpc_q + 32'd1;
        end

        // A redirect drops everything buffered and the returning word; the pop above still counts.
        if (redirect_valid) begin
            fpc_d      = redirect_pc;
            occ_d      = 2'd0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fpc_q        <= RESET_PC;
            inflight_q   <= 1'b0;
            inflightPc_q <= 32'd0;
            fifoInst_q   <= '{default: 32'd0};
            fifoPc_q     <= '{default: 32'd0};
            occ_q        <= 2'd0;
        end else begin
            fpc_q        <= fpc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            fifoInst_q   <= fifoInst_d;
            fifoPc_q     <= fifoPc_d;
            occ_q        <= occ_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetchCnt_q;
    logic [31:0] flushCnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetchCnt_q <= 32'd0;
            flushCnt_q <= 32'd0;
        end else begin
            if (pop) begin
                fetchCnt_q <= fetchCnt_q + 32'd1;
            end
            if (redirect_valid && ((occ_q != 2'd0) || inflight_q)) begin
                flushCnt_q <= flushCnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetchCnt_q;
    assign perf_flush_cnt = flushCnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for streaming, redirects, wrap and reset,
// plus hand-written backpressure and (with FETCH_PERF_EN) counter sequences.
module tb_fetch_unit;

    localparam int PC_W = 12;

    logic            clock;
    logic            reset;
    logic            redirectValid;
    logic [31:0]     redirectPc;
    logic [PC_W-1:0] addressImem;
    logic [31:0]     qImem;
    logic            instValid;
    logic            instReady;
    logic [31:0]     instOut;
    logic [31:0]     instPc;
`ifdef FETCH_PERF_EN
    logic [31:0]     perfFetchCnt;
    logic [31:0]     perfFlushCnt;
`endif

    int total;
    int bad;

    fetch_unit #(.PC_W(PC_W), .RESET_PC(32'h0)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .address_imem   (addressImem),
        .q_imem         (qImem),
        .inst_valid     (instValid),
        .inst_ready     (instReady),
        .inst_out       (instOut),
        .inst_pc        (instPc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perfFetchCnt),
        .perf_flush_cnt (perfFlushCnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // imem holds 0x1000 + address, read with one cycle of latency.
    always @(posedge clock) qImem <= 32'h1000 + {20'd0, addressImem};

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInst;
    } vec_t;

    vec_t vecs[$];

    task automatic applyStimulus(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc);
        reset         = rst;
        instReady     = rdy;
        redirectValid = redir;
        redirectPc    = rpc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int nextPc;
        total = 0;
        bad   = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

        // rst rdy redir rpc | addr valid pc inst ; rows are consecutive cycles after release
        vecs.push_back('{0, 1, 0, 32'h0,        32'h000, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h001, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h002, 1, 32'h0,        32'h1000});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h003, 1, 32'h1,        32'h1001});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h004, 1, 32'h2,        32'h1002});
        vecs.push_back('{0, 1, 1, 32'h40,       32'h005, 1, 32'h3,        32'h1003});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h040, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h041, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h042, 1, 32'h40,       32'h1040});
        vecs.push_back('{0, 0, 0, 32'h0,        32'h043, 1, 32'h41,       32'h1041});
        vecs.push_back('{0, 0, 1, 32'h80,       32'h043, 1, 32'h41,       32'h1041});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h080, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h081, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h082, 1, 32'h80,       32'h1080});
        vecs.push_back('{0, 1, 1, 32'h100,      32'h083, 1, 32'h81,       32'h1081});
        vecs.push_back('{0, 1, 1, 32'h200,      32'h100, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h200, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h201, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 1, 32'hFFFFFFFF, 32'h202, 1, 32'h200,      32'h1200});
        vecs.push_back('{0, 1, 0, 32'h0,        32'hFFF, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h000, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h001, 1, 32'hFFFFFFFF, 32'h1FFF});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h002, 1, 32'h0,        32'h1000});
        vecs.push_back('{1, 1, 1, 32'h80,       32'h003, 1, 32'h1,        32'h1001});
        vecs.push_back('{1, 1, 1, 32'h80,       32'h000, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h000, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h001, 0, 32'h0,        32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        32'h002, 1, 32'h0,        32'h1000});

        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("reset_valid", {31'd0, instValid}, 32'd0);
        checkOutput("reset_pc",    instPc,             32'd0);
        checkOutput("reset_inst",  instOut,            32'd0);
        checkOutput("reset_addr",  {20'd0, addressImem}, 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            checkOutput($sformatf("vec%0d_addr", i), {20'd0, addressImem}, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, instValid}, {31'd0, vecs[i].expValid});
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d_pc", i), instPc, vecs[i].expPc);
                checkOutput($sformatf("vec%0d_inst", i), instOut, vecs[i].expInst);
            end
            nextCycle();
        end

        // Now in cycle 3 after release: head pc1, pc2 in flight, fpc=3. Stall decode for 5 cycles.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            checkOutput($sformatf("stall%0d_valid", k), {31'd0, instValid}, 32'd1);
            checkOutput($sformatf("stall%0d_pc", k), instPc, 32'd1);
            checkOutput($sformatf("stall%0d_inst", k), instOut, 32'h1001);
            checkOutput($sformatf("stall%0d_addr", k), {20'd0, addressImem}, 32'd3);
            nextCycle();
        end

        nextPc = 1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
            checkOutput($sformatf("drain%0d_valid", k), {31'd0, instValid}, 32'd1);
            if (instValid) begin
                checkOutput($sformatf("drain%0d_pc", k), instPc, nextPc);
                checkOutput($sformatf("drain%0d_inst", k), instOut, 32'h1000 + nextPc);
                nextPc++;
            end
            nextCycle();
        end
        checkOutput("drain_count", nextPc, 32'd9);

`ifdef FETCH_PERF_EN
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("perf_reset_fetch", perfFetchCnt, 32'd0);
        checkOutput("perf_reset_flush", perfFlushCnt, 32'd0);
        for (int k = 0; k < 12; k++) nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("perf_fetch10", perfFetchCnt, 32'd10);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h300);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h400);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("perf_fetch_final", perfFetchCnt, 32'd10);
        checkOutput("perf_flush_final", perfFlushCnt, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
